// File: rtl/fir_sample_loader.sv
// rtl/fir_sample_loader.sv - FIFO-to-IMEM sample loader feeding the 64-tap FIR ALU.
// Optional power-on zero-fill of the delay line is enabled by defining FIR_LOADER_CLEAR_EN.
module fir_sample_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_out,
    output logic              fifo_rd,
    output logic              imem_cen,
    output logic              imem_wen,
    output logic [ADDR_W-1:0] imem_a,
    output logic [DATA_W-1:0] imem_d,
    output logic              alu_start,
    output logic [ADDR_W-1:0] alu_base,
    input  logic              alu_done,
    output logic              primed,
    output logic              init_done
);
    localparam logic [2:0] CLEAR = 3'd0;
    localparam logic [2:0] IDLE  = 3'd1;
    localparam logic [2:0] POP   = 3'd2;
    localparam logic [2:0] CAPT  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] START = 3'd5;
    localparam logic [2:0] WAIT  = 3'd6;

`ifdef FIR_LOADER_CLEAR_EN
    localparam logic [2:0] RESET_STATE = CLEAR;
`else
    localparam logic [2:0] RESET_STATE = IDLE;
`endif

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] sample;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (a_q == ADDR_LAST) state_nxt = IDLE;
            IDLE:    if (!fifo_empty) state_nxt = POP;
            POP:     state_nxt = CAPT;
            CAPT:    state_nxt = WRITE;
            WRITE:   state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (alu_done) state_nxt = IDLE;
            default: state_nxt = RESET_STATE;
        endcase
    end

    // a_q doubles as the zero-fill address counter and the held IMEM address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= RESET_STATE;
            wptr     <= '0;
            count    <= '0;
            sample   <= '0;
            a_q      <= '0;
            d_q      <= '0;
            alu_base <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                CLEAR: begin
                    if (a_q != ADDR_LAST) a_q <= a_q + 1'b1;
                end
                CAPT: begin
                    sample <= fifo_out;
                end
                WRITE: begin
                    a_q      <= wptr;
                    d_q      <= sample;
                    alu_base <= wptr;
                    wptr     <= wptr + 1'b1;
                    if (count != '1) count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fifo_rd   = (state == POP);
    assign alu_start = (state == START);
    // The reset state may be CLEAR; rstn keeps the IMEM deselected while reset is held.
    assign imem_cen  = !((state == CLEAR && rstn) || state == WRITE);
    assign imem_wen  = imem_cen;
    assign imem_a    = (state == WRITE) ? wptr : a_q;
    assign imem_d    = (state == WRITE) ? sample : d_q;
    assign primed    = count[ADDR_W];

`ifdef FIR_LOADER_CLEAR_EN
    assign init_done = (state != CLEAR);
`else
    assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_fir_sample_loader.sv
// tb/tb_fir_sample_loader.sv - scoreboard bench for fir_sample_loader.
`timescale 1ns/1ps
module tb_fir_sample_loader;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
`ifdef FIR_LOADER_CLEAR_EN
    localparam logic INIT_RST = 1'b0;
`else
    localparam logic INIT_RST = 1'b1;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_out = '0;
    logic              fifo_rd;
    logic              imem_cen;
    logic              imem_wen;
    logic [ADDR_W-1:0] imem_a;
    logic [DATA_W-1:0] imem_d;
    logic              alu_start;
    logic [ADDR_W-1:0] alu_base;
    logic              alu_done;
    logic              primed;
    logic              init_done;
    logic              alu_done_model = 1'b0;
    logic              alu_done_force = 1'b0;

    fir_sample_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_out(fifo_out),
        .fifo_rd(fifo_rd), .imem_cen(imem_cen), .imem_wen(imem_wen),
        .imem_a(imem_a), .imem_d(imem_d), .alu_start(alu_start),
        .alu_base(alu_base), .alu_done(alu_done), .primed(primed),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    assign alu_done = alu_done_model | alu_done_force;

    // FIFO model: read data appears the cycle after the pop strobe.
    logic [DATA_W-1:0] fifo_mem [0:255];
    int push_cnt = 0;
    int pop_cnt = 0;
    assign fifo_empty = (push_cnt == pop_cnt);
    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_out <= fifo_mem[pop_cnt[7:0]];
            pop_cnt  <= pop_cnt + 1;
        end
    end

    typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
    typedef struct packed { logic [ADDR_W-1:0] base; logic primed; } st_t;
    wr_t exp_wr[$];
    st_t exp_st[$];
    logic [DATA_W-1:0] shadow [0:63];

    int errors = 0;
    int checks = 0;
    int rd_count = 0;
    int wr_count = 0;
    int start_count = 0;
    int wptr_m = 0;
    int count_m = 0;
    bit alu_auto = 1'b1;
    int alu_lat = 10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_sample(input logic [DATA_W-1:0] v);
        fifo_mem[push_cnt[7:0]] = v;
        push_cnt++;
        exp_wr.push_back({wptr_m[ADDR_W-1:0], v});
        if (count_m < 127) count_m++;
        exp_st.push_back({wptr_m[ADDR_W-1:0], (count_m >= 64)});
        wptr_m = (wptr_m + 1) % 64;
    endtask

    task automatic release_reset();
`ifdef FIR_LOADER_CLEAR_EN
        for (int k = 0; k < 64; k++) exp_wr.push_back({k[ADDR_W-1:0], {DATA_W{1'b0}}});
`endif
        rstn = 1'b1;
    endtask

    task automatic monitor();
        wr_t w;
        st_t s;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (fifo_rd) rd_count++;
                if (!imem_cen || !imem_wen) begin
                    wr_count++;
                    shadow[imem_a] = imem_d;
                    check("write_expected", exp_wr.size() > 0, 1);
                    if (exp_wr.size() > 0) begin
                        w = exp_wr.pop_front();
                        check("imem_write", {imem_cen, imem_wen, imem_a, imem_d}, {2'b00, w.a, w.d});
                    end
                end
                if (alu_start) begin
                    start_count++;
                    check("start_expected", exp_st.size() > 0, 1);
                    if (exp_st.size() > 0) begin
                        s = exp_st.pop_front();
                        check("alu_base_primed", {alu_base, primed}, {s.base, s.primed});
                    end
                end
            end
        end
    endtask

    task automatic alu_model();
        forever begin
            @(negedge clk);
            if (alu_auto && rstn && alu_start) begin
                repeat (alu_lat) @(negedge clk);
                alu_done_model = 1'b1;
                @(negedge clk);
                alu_done_model = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_wr.size() > 0 || exp_st.size() > 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", exp_wr.size() + exp_st.size(), 0);
    endtask

    initial begin
        int rd0;
        int s0;
        fork
            monitor();
            alu_model();
        join_none

        repeat (2) @(negedge clk);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_imem", {imem_cen, imem_wen, imem_a, imem_d}, {2'b11, 6'd0, 16'd0});
        check("rst_alu", {alu_start, alu_base, primed}, 0);
        check("rst_init_done", init_done, INIT_RST);

        @(posedge clk); #1;
        release_reset();
`ifdef FIR_LOADER_CLEAR_EN
        repeat (64) @(negedge clk);
        check("clear_init_low", init_done, 0);
        @(negedge clk);
        check("clear_init_high", init_done, 1);
        check("clear_writes", wr_count, 64);
        check("clear_no_pop", rd_count, 0);
        wait_drain(10);
`else
        @(negedge clk);
        check("init_done_out_of_reset", init_done, 1);
        check("no_clear_writes", wr_count, 0);
`endif

        // Single sample, ALU answers 10 cycles after start.
        alu_auto = 1'b1;
        alu_lat  = 10;
        @(posedge clk); #1;
        push_sample(16'h1234);
        @(negedge clk); check("lat_idle_rd", fifo_rd, 0);
        @(negedge clk); check("lat_pop_rd", fifo_rd, 1);
        @(negedge clk); check("lat_capt", {fifo_rd, imem_cen}, 2'b01);
        @(negedge clk); check("lat_write", {imem_cen, imem_wen, imem_a, imem_d}, {2'b00, 6'd0, 16'h1234});
        @(negedge clk); check("lat_start", {alu_start, alu_base}, {1'b1, 6'd0});
        repeat (14) @(negedge clk);
        check("after_done_quiet", {fifo_rd, imem_cen, alu_start}, 3'b010);
        check("single_pop_total", rd_count, 1);

        // Spurious done in IDLE and POP, then done held for three cycles in WAIT.
        alu_auto = 1'b0;
        rd0 = rd_count;
        s0  = start_count;
        @(posedge clk); #1 alu_done_force = 1'b1;
        @(negedge clk); check("idle_done_ignored", {fifo_rd, imem_cen, alu_start}, 3'b010);
        @(posedge clk); #1 alu_done_force = 1'b0;
        push_sample(16'hA5A5);
        @(posedge clk); #1 alu_done_force = 1'b1;
        @(negedge clk); check("spur_pop", fifo_rd, 1);
        @(posedge clk); #1 alu_done_force = 1'b0;
        @(negedge clk); check("spur_capt", {fifo_rd, imem_cen}, 2'b01);
        @(negedge clk); check("spur_write", {imem_cen, imem_a, imem_d}, {1'b0, 6'd1, 16'hA5A5});
        @(negedge clk); check("spur_start", {alu_start, alu_base}, {1'b1, 6'd1});
        @(posedge clk); #1;
        push_sample(16'h0F0F);
        repeat (5) @(negedge clk);
        check("wait_no_pop", rd_count - rd0, 1);
        @(posedge clk); #1 alu_done_force = 1'b1;
        @(negedge clk);
        @(negedge clk); check("done_then_idle", fifo_rd, 0);
        @(negedge clk); check("done_then_pop", fifo_rd, 1);
        @(posedge clk); #1 alu_done_force = 1'b0;
        repeat (8) @(negedge clk);
        check("single_pop_per_done", rd_count - rd0, 2);
        check("single_start_per_done", start_count - s0, 2);
        check("base_held_in_wait", alu_base, 2);

        // Asynchronous reset while parked in WAIT.
        @(negedge clk); #1 rstn = 1'b0;
        #1;
        check("async_rst_imem", {imem_cen, imem_wen, imem_a, imem_d}, {2'b11, 6'd0, 16'd0});
        check("async_rst_alu", {fifo_rd, alu_start, alu_base, primed}, 0);
        check("async_rst_init", init_done, INIT_RST);
        check("sb_empty_at_reset", exp_wr.size() + exp_st.size(), 0);
        wptr_m  = 0;
        count_m = 0;
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        wait_drain(80);

        // 70 samples valued k: wraps 63->0 and primes on the 64th write.
        alu_auto = 1'b1;
        alu_lat  = 2;
        @(posedge clk); #1;
        for (int k = 0; k < 70; k++) push_sample(k[DATA_W-1:0]);
        wait_drain(70 * 12 + 100);
        repeat (6) @(negedge clk);
        check("wrap_addr5", shadow[5], 69);
        check("wrap_addr0", shadow[0], 64);
        check("wrap_addr6", shadow[6], 6);
        check("wrap_addr63", shadow[63], 63);
        check("primed_final", primed, 1);
        check("pop_total", rd_count, 73);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/fir_sample_loader.md
# fir_sample_loader

Read-side controller between `fir_fifo` and `fir_imem` in the 16-bit 64-tap FIR datapath, running in the 640 kHz read-clock domain. Pops one input sample at a time from the FIFO and writes it into a 64-entry circular delay line in `fir_imem`. Then pulses the FIR ALU with the newest-sample address and holds off the next pop until the ALU reports done.

## Interface
- `ADDR_W`, default 6: IMEM address width; depth = 2^ADDR_W = 64 taps.
- `DATA_W`, default 16: sample width.

Ports:
- `clk`, in, 1: read-side clock, 640 kHz (same net as `fir_fifo` clk2 and `fir_imem` clk).
- `rstn`, in, 1: reset, asynchronous, active-low.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_out`, in, DATA_W: FIFO read data; valid on the cycle after `fifo_rd`.
- `fifo_rd`, out, 1: one-cycle pop strobe.
- `imem_cen`, out, 1: IMEM chip enable, active-low.
- `imem_wen`, out, 1: IMEM write enable, active-low.
- `imem_a`, out, ADDR_W: IMEM address.
- `imem_d`, out, DATA_W: IMEM write data.
- `alu_start`, out, 1: one-cycle start pulse to the FIR ALU.
- `alu_base`, out, ADDR_W: address of the newest sample; held stable from `alu_start` until `alu_done`.
- `alu_done`, in, 1: ALU finished the current output sample.
- `primed`, out, 1: high once 64 samples have been written since reset.
- `init_done`, out, 1: high when the loader is ready to accept samples.

## Operation
- FSM states: CLEAR, IDLE, POP, CAPT, WRITE, START, WAIT.
- CLEAR (see Configuration):
  - Write 0 to addresses 0..63, one per cycle, with `imem_cen`=0 and `imem_wen`=0.
  - Go to IDLE after address 63.
- IDLE: if `fifo_empty`=0, go to POP; otherwise stay.
- POP: `fifo_rd`=1 for exactly one cycle; go to CAPT.
- CAPT: register `fifo_out` into the sample register; go to WRITE.
- WRITE:
  - Drive `imem_cen`=0, `imem_wen`=0, `imem_a`=wptr, `imem_d`=sample.
  - Latch `alu_base`=wptr.
  - wptr <= wptr+1 mod 64; 63 wraps to 0.
  - Go to START.
- START: `alu_start`=1 for one cycle; go to WAIT.
- WAIT: stay until `alu_done`=1, then go to IDLE.
- `alu_done` in any state other than WAIT is ignored.
- Sample count: saturating 7-bit counter, incremented in WRITE; `primed` = (count ≥ 64).
- Outside CLEAR/WRITE: `imem_cen`=1, `imem_wen`=1. `imem_a` and `imem_d` hold their last values.
- Sample is treated as raw bits; no sign handling or arithmetic in this block.

## Timing
- Reset values:
  - `fifo_rd`=0, `imem_cen`=1, `imem_wen`=1, `imem_a`=0, `imem_d`=0.
  - `alu_start`=0, `alu_base`=0, `primed`=0, wptr=0, count=0.
  - `init_done`=0 with the macro, 1 without.
- Latency from the first edge with `fifo_empty`=0 in IDLE:
  - POP at +1, IMEM write at +3, `alu_start` at +4.
  - Minimum of 6 cycles per sample, including the cycle `alu_done` is seen plus the return to IDLE.
- At 10 kHz input versus 640 kHz, 64 cycles are available per sample. An ALU taking more than about 58 cycles backs up the FIFO. This is not detected here; the FIFO's `fifo_full` covers it.
- `fifo_empty` is sampled only in IDLE; a FIFO refill during WAIT is picked up on return to IDLE.
- `alu_done` and a new sample arriving in the same cycle: return to IDLE first, POP next cycle.
- Reset asserted mid-operation: every output returns to its reset value immediately. A pop already strobed is lost, and the IMEM contents are stale. With the macro, CLEAR restarts on release.

## Configuration
- `FIR_LOADER_CLEAR_EN`:
  - Defined: reset enters CLEAR. The 64-cycle zero-fill runs before IDLE; `init_done` rises on the first IDLE cycle (reset release + 64 cycles). The delay line starts zeroed, so outputs before `primed` are valid partial sums.
  - Undefined: reset enters IDLE directly and `init_done`=1. IMEM contents are undefined until `primed`.

## Test plan
- Macro defined, release reset, FIFO empty -> 64 IMEM writes of 0 at addresses 0..63, `init_done` high at cycle 64, no `fifo_rd`.
- Single sample 0x1234, ALU model returns `alu_done` 10 cycles after `alu_start` -> `fifo_rd` at +1, write {A=wptr, D=0x1234} at +3, `alu_start` at +4 with `alu_base`=wptr, back to IDLE after done.
- 70 samples (value k for sample k) -> addresses wrap 63→0, address 5 finally holds 69, `primed` rises on the 64th write.
- Spurious `alu_done` in IDLE and POP -> no state change; `alu_done` held high for 3 cycles in WAIT -> exactly one return to IDLE, no double pop.
- `rstn` low during WAIT -> all outputs at reset values in the same cycle; after release, CLEAR reruns and wptr=0.
- Macro undefined -> `init_done`=1 out of reset, first sample written at address 0 at +3 cycles.
